idct_1d: RTL and testbench

Inverse 1D-DCT on 1x8 windows: collects eight serial signed DCT coefficients (F[0]..F[7], one per beat) and emits the eight reconstructed pixels packed into one output beat. Inverse counterpart of the forward 1D-DCT stage; sits on the JPEG decode / verification path and restores the forward stage's 1x8 packed pixel format.

---
 rtl/axi4_stream_if.sv | 17 +
 rtl/idct_1d.sv | 201 ++++++++++++++++++++
 tb/tb_idct_1d.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream style handshake bundle with master/slave views
interface axi4_stream_if #(
    parameter int DATA_W = 8
) ();
    localparam int KEEP_W = (DATA_W + 7) / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, tkeep, tstrb, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tstrb, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/idct_1d.sv
// rtl/idct_1d.sv - 8-point inverse 1D-DCT: serial coefficients in, packed 1x8 pixel beat out
module idct_1d #(
    parameter int PX_WIDTH         = 8,
    parameter int COEF_WIDTH       = 11,
    parameter int FRACT_WIDTH      = 0,
    parameter int COEF_FRACT_WIDTH = 12,
    parameter int LEVEL_SHIFT      = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  coef_i,
    axi4_stream_if.master video_o
);
    localparam int S  = COEF_FRACT_WIDTH + FRACT_WIDTH;
    localparam int KW = COEF_FRACT_WIDTH + 2;
    localparam int PW = COEF_WIDTH + KW;
    localparam int FW = PW + 3;
    localparam int OW = 8 * PX_WIDTH;

    // Cosine constants are kept at 20 fractional bits and rounded down to COEF_FRACT_WIDTH (<= 20).
    function automatic int cos_const(input int q20);
        int sh;
        sh = 20 - COEF_FRACT_WIDTH;
        if (sh <= 0) return q20;
        return (q20 + (1 << (sh - 1))) >>> sh;
    endfunction

    localparam logic signed [KW-1:0] C1 = KW'(cos_const(514214));
    localparam logic signed [KW-1:0] C2 = KW'(cos_const(484379));
    localparam logic signed [KW-1:0] C3 = KW'(cos_const(435930));
    localparam logic signed [KW-1:0] C4 = KW'(cos_const(370728));
    localparam logic signed [KW-1:0] C5 = KW'(cos_const(291279));
    localparam logic signed [KW-1:0] C6 = KW'(cos_const(200636));
    localparam logic signed [KW-1:0] C7 = KW'(cos_const(102284));

    localparam logic signed [FW-1:0] RND_C = FW'(1) <<< (S - 1);
    localparam logic signed [FW-1:0] LVL_C = (LEVEL_SHIFT != 0) ? (FW'(1) <<< (PX_WIDTH - 1)) : '0;
    localparam logic signed [FW-1:0] MAX_C = (LEVEL_SHIFT != 0) ? ((FW'(1) <<< PX_WIDTH) - FW'(1))
                                                                : ((FW'(1) <<< (PX_WIDTH - 1)) - FW'(1));
    localparam logic signed [FW-1:0] MIN_C = (LEVEL_SHIFT != 0) ? '0 : -(FW'(1) <<< (PX_WIDTH - 1));

    function automatic logic signed [KW-1:0] kodd(input int j);
        case (j)
            0:       return C1;
            1:       return C3;
            2:       return C5;
            default: return C7;
        endcase
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic signed [COEF_WIDTH-1:0] a,
                                                 input logic signed [KW-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic signed [FW-1:0] ext(input logic signed [PW-1:0] p);
        return FW'(p);
    endfunction

    function automatic logic [PX_WIDTH-1:0] scale(input logic signed [FW-1:0] f);
        logic signed [FW-1:0] r;
        r = ((f + RND_C) >>> S) + LVL_C;
        if (r > MAX_C) return MAX_C[PX_WIDTH-1:0];
        if (r < MIN_C) return MIN_C[PX_WIDTH-1:0];
        return r[PX_WIDTH-1:0];
    endfunction

    logic                         rdy_en_q;
    logic [2:0]                   idx_q, idx_d;
    logic signed [COEF_WIDTH-1:0] win_q [8];
    logic                         win_user_q;

    logic signed [COEF_WIDTH-1:0] coef_data;
    logic [2:0]                   slot;
    logic                         adv, in_ready, accept, win_done, drop, store;

    logic                         s0_v_q, s0_u_q, s0_l_q;
    logic signed [COEF_WIDTH-1:0] s0_f_q [8];
    logic                         s1_v_q, s1_u_q, s1_l_q;
    logic signed [PW-1:0]         s1_pe_q [6];
    logic signed [PW-1:0]         s1_po_q [4][4];
    logic                         s2_v_q, s2_u_q, s2_l_q;
    logic signed [FW-1:0]         s2_e_q [4];
    logic signed [FW-1:0]         s2_o_q [4];
    logic                         out_valid_q, out_user_q, out_last_q;
    logic [OW-1:0]                out_data_q;

    logic signed [PW-1:0]         pe_d [6];
    logic signed [PW-1:0]         po_d [4][4];
    logic signed [FW-1:0]         e_d [4];
    logic signed [FW-1:0]         o_d [4];
    logic [OW-1:0]                px_d;

    // A tuser beat always restarts the window at slot 0, whatever idx was.
    always_comb begin
        coef_data = coef_i.tdata[COEF_WIDTH-1:0];
        adv       = !out_valid_q || video_o.tready;
        in_ready  = rdy_en_q && ((idx_q != 3'd7) || adv);
        accept    = coef_i.tvalid && in_ready;
        slot      = coef_i.tuser ? 3'd0 : idx_q;
        win_done  = accept && (slot == 3'd7);
        drop      = accept && coef_i.tlast && (slot != 3'd7);
        store     = accept && !drop && (slot != 3'd7);
        idx_d     = idx_q;
        if (drop || win_done) idx_d = 3'd0;
        else if (store)       idx_d = slot + 3'd1;
    end

    assign coef_i.tready  = in_ready;
    assign video_o.tdata  = out_data_q;
    assign video_o.tvalid = out_valid_q;
    assign video_o.tuser  = out_user_q;
    assign video_o.tlast  = out_last_q;
    assign video_o.tkeep  = '1;
    assign video_o.tstrb  = '1;

    logic unused_in;
    assign unused_in = ^{coef_i.tdata, coef_i.tkeep, coef_i.tstrb};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdy_en_q   <= 1'b0;
            idx_q      <= 3'd0;
            win_user_q <= 1'b0;
            for (int i = 0; i < 8; i++) win_q[i] <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            idx_q    <= idx_d;
            if (store) begin
                win_q[slot] <= coef_data;
                if (slot == 3'd0) win_user_q <= coef_i.tuser;
            end
        end
    end

    always_comb begin
        pe_d[0] = mul(s0_f_q[0], C4);
        pe_d[1] = mul(s0_f_q[4], C4);
        pe_d[2] = mul(s0_f_q[2], C2);
        pe_d[3] = mul(s0_f_q[2], C6);
        pe_d[4] = mul(s0_f_q[6], C2);
        pe_d[5] = mul(s0_f_q[6], C6);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                po_d[i][j] = mul(s0_f_q[2*i+1], kodd(j));
    end

    // po index [i][j]: coefficient F(2i+1) times C(2j+1).
    always_comb begin
        e_d[0] = ext(s1_pe_q[0]) + ext(s1_pe_q[2]) + ext(s1_pe_q[1]) + ext(s1_pe_q[5]);
        e_d[1] = ext(s1_pe_q[0]) + ext(s1_pe_q[3]) - ext(s1_pe_q[1]) - ext(s1_pe_q[4]);
        e_d[2] = ext(s1_pe_q[0]) - ext(s1_pe_q[3]) - ext(s1_pe_q[1]) + ext(s1_pe_q[4]);
        e_d[3] = ext(s1_pe_q[0]) - ext(s1_pe_q[2]) + ext(s1_pe_q[1]) - ext(s1_pe_q[5]);
        o_d[0] = ext(s1_po_q[0][0]) + ext(s1_po_q[1][1]) + ext(s1_po_q[2][2]) + ext(s1_po_q[3][3]);
        o_d[1] = ext(s1_po_q[0][1]) - ext(s1_po_q[1][3]) - ext(s1_po_q[2][0]) - ext(s1_po_q[3][2]);
        o_d[2] = ext(s1_po_q[0][2]) - ext(s1_po_q[1][0]) + ext(s1_po_q[2][3]) + ext(s1_po_q[3][1]);
        o_d[3] = ext(s1_po_q[0][3]) - ext(s1_po_q[1][2]) + ext(s1_po_q[2][1]) - ext(s1_po_q[3][0]);
    end

    always_comb begin
        px_d = '0;
        for (int n = 0; n < 4; n++) begin
            px_d[n*PX_WIDTH +: PX_WIDTH]     = scale(s2_e_q[n] + s2_o_q[n]);
            px_d[(7-n)*PX_WIDTH +: PX_WIDTH] = scale(s2_e_q[n] - s2_o_q[n]);
        end
    end

    // The whole pipeline moves together; a stalled output freezes every stage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {s0_v_q, s0_u_q, s0_l_q} <= '0;
            {s1_v_q, s1_u_q, s1_l_q} <= '0;
            {s2_v_q, s2_u_q, s2_l_q} <= '0;
            {out_valid_q, out_user_q, out_last_q} <= '0;
            out_data_q <= '0;
            for (int i = 0; i < 8; i++) s0_f_q[i] <= '0;
            for (int i = 0; i < 6; i++) s1_pe_q[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                s2_e_q[i] <= '0;
                s2_o_q[i] <= '0;
                for (int j = 0; j < 4; j++) s1_po_q[i][j] <= '0;
            end
        end else if (adv) begin
            s0_v_q <= win_done;
            if (win_done) begin
                for (int i = 0; i < 7; i++) s0_f_q[i] <= win_q[i];
                s0_f_q[7] <= coef_data;
                s0_u_q    <= win_user_q;
                s0_l_q    <= coef_i.tlast;
            end
            {s1_v_q, s1_u_q, s1_l_q} <= {s0_v_q, s0_u_q, s0_l_q};
            s1_pe_q <= pe_d;
            s1_po_q <= po_d;
            {s2_v_q, s2_u_q, s2_l_q} <= {s1_v_q, s1_u_q, s1_l_q};
            s2_e_q <= e_d;
            s2_o_q <= o_d;
            {out_valid_q, out_user_q, out_last_q} <= {s2_v_q, s2_u_q, s2_l_q};
            out_data_q <= px_d;
        end
    end
endmodule

// File: tb/tb_idct_1d.sv
// tb/tb_idct_1d.sv - directed bench for idct_1d with hand-computed pixel vectors
module tb_idct_1d;
    localparam int TWI = 16;
    localparam int TWO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_W(TWI)) coef ();
    axi4_stream_if #(.DATA_W(TWO)) video ();
    axi4_stream_if #(.DATA_W(TWI)) coef_ls ();
    axi4_stream_if #(.DATA_W(TWO)) video_ls ();

    assign coef.tkeep      = '1;
    assign coef.tstrb      = '1;
    assign coef_ls.tdata   = coef.tdata;
    assign coef_ls.tvalid  = coef.tvalid && coef.tready;
    assign coef_ls.tuser   = coef.tuser;
    assign coef_ls.tlast   = coef.tlast;
    assign coef_ls.tkeep   = '1;
    assign coef_ls.tstrb   = '1;
    assign video_ls.tready = 1'b1;

    idct_1d dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .coef_i  (coef.slave),
        .video_o (video.master)
    );

    idct_1d #(.LEVEL_SHIFT(1)) dut_ls (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .coef_i  (coef_ls.slave),
        .video_o (video_ls.master)
    );

    int n_chk = 0;
    int n_pass = 0;
    int in_hs = 0;
    int bp_base;
    logic [65:0] out_q[$];
    logic bp_seen, bp_changed;
    logic [63:0] bp_held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (video.tvalid && video.tready)
                out_q.push_back({video.tuser, video.tlast, video.tdata});
            if (coef.tvalid && coef.tready) in_hs++;
        end
    end

    function automatic logic [63:0] rep(input int v);
        logic [63:0] r;
        for (int n = 0; n < 8; n++) r[n*8 +: 8] = 8'(v);
        return r;
    endfunction

    // Bits above the 11-bit coefficient carry junk the DUT must ignore.
    task automatic send_beat(input logic [10:0] d, input logic u, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        coef.tdata  = {5'b10110, d};
        coef.tuser  = u;
        coef.tlast  = l;
        coef.tvalid = 1'b1;
        #2;
        while (!coef.tready && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 200) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        coef.tvalid = 1'b0;
        coef.tuser  = 1'b0;
        coef.tlast  = 1'b0;
    endtask

    task automatic send_dc(input int f0, input logic u, input logic l);
        for (int k = 0; k < 8; k++)
            send_beat((k == 0) ? 11'(f0) : 11'd0, u && (k == 0), l && (k == 7));
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] d, input logic u, input logic l);
        int t;
        logic [65:0] b;
        t = 0;
        while (out_q.size() == 0 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (out_q.size() == 0) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        b = out_q.pop_front();
        chk({tag, "_data"}, b[63:0], d);
        chk({tag, "_user"}, 64'(b[65]), 64'(u));
        chk({tag, "_last"}, 64'(b[64]), 64'(l));
    endtask

    task automatic expect_idle(input string tag);
        repeat (12) @(negedge clk);
        #2;
        chk(tag, 64'(out_q.size()), 64'd0);
    endtask

    task automatic window_lat(input string tag, input int f0, input logic [63:0] exp_ls);
        send_dc(f0, 1'b0, 1'b0);
        chk({tag, "_lat0"}, 64'(video.tvalid), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_lat"}, 64'(video.tvalid), (k == 3) ? 64'd1 : 64'd0);
        end
        chk({tag, "_ls"}, video_ls.tdata, exp_ls);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int a[8];
        logic [63:0] e;
        coef.tdata  = '0;
        coef.tvalid = 1'b0;
        coef.tuser  = 1'b0;
        coef.tlast  = 1'b0;
        video.tready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", 64'(video.tvalid), 64'd0);
        chk("rst_tdata", video.tdata, 64'd0);
        chk("rst_tuser", 64'(video.tuser), 64'd0);
        chk("rst_tlast", 64'(video.tlast), 64'd0);
        chk("rst_tready", 64'(coef.tready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_tready", 64'(coef.tready), 64'd1);

        window_lat("dc64", 64, rep(151));
        expect_beat("dc64", rep(23), 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) send_beat((k == 1) ? 11'd100 : 11'd0, 1'b0, 1'b0);
        a = '{49, 42, 28, 10, -10, -28, -42, -49};
        for (int n = 0; n < 8; n++) e[n*8 +: 8] = 8'(a[n]);
        expect_beat("f1_100", e, 1'b0, 1'b0);

        send_dc(1023, 1'b0, 1'b0);
        expect_beat("sat_pos", rep(127), 1'b0, 1'b0);
        window_lat("sat_neg", -1024, rep(0));
        expect_beat("sat_neg", rep(-128), 1'b0, 1'b0);

        @(negedge clk);
        video.tready = 1'b0;
        bp_base = in_hs;
        bp_seen = 1'b0;
        bp_changed = 1'b0;
        bp_held = '0;
        fork
            begin
                send_dc(64, 1'b0, 1'b0);
                send_dc(128, 1'b0, 1'b0);
                send_dc(-64, 1'b0, 1'b0);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    #1;
                    if (video.tvalid) begin
                        if (!bp_seen) begin
                            bp_seen = 1'b1;
                            bp_held = video.tdata;
                        end else if (video.tdata !== bp_held) bp_changed = 1'b1;
                    end
                end
                chk("bp_beats", 64'(in_hs - bp_base), 64'd15);
                chk("bp_tready", 64'(coef.tready), 64'd0);
                chk("bp_tvalid", 64'(video.tvalid), 64'd1);
                chk("bp_stable", 64'(bp_changed), 64'd0);
                chk("bp_held", video.tdata, rep(23));
                @(negedge clk);
                video.tready = 1'b1;
            end
        join
        expect_beat("bp0", rep(23), 1'b0, 1'b0);
        expect_beat("bp1", rep(45), 1'b0, 1'b0);
        expect_beat("bp2", rep(-23), 1'b0, 1'b0);
        expect_idle("bp_nodup");

        send_dc(64, 1'b1, 1'b0);
        send_dc(128, 1'b0, 1'b0);
        send_dc(-64, 1'b0, 1'b0);
        send_dc(64, 1'b0, 1'b1);
        expect_beat("frm0", rep(23), 1'b1, 1'b0);
        expect_beat("frm1", rep(45), 1'b0, 1'b0);
        expect_beat("frm2", rep(-23), 1'b0, 1'b0);
        expect_beat("frm3", rep(23), 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) send_beat(11'd500, 1'b0, 1'b0);
        send_dc(64, 1'b1, 1'b0);
        expect_beat("resync", rep(23), 1'b1, 1'b0);
        expect_idle("resync_idle");

        for (int k = 0; k < 6; k++) send_beat(11'd300, 1'b0, k == 5);
        expect_idle("early_last_drop");
        send_dc(-64, 1'b0, 1'b0);
        expect_beat("after_drop", rep(-23), 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) send_beat(11'd500, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tready", 64'(coef.tready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("mid_rst_idle");

        @(negedge clk);
        video.tready = 1'b0;
        send_dc(128, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) send_beat((k == 0) ? 11'd1023 : 11'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        chk("flight_tvalid", 64'(video.tvalid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        video.tready = 1'b1;
        #1;
        chk("flight_rst_tvalid", 64'(video.tvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("flight_idle");
        send_dc(64, 1'b0, 1'b0);
        expect_beat("post_rst", rep(23), 1'b0, 1'b0);
        expect_idle("post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
